// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM state encoding
// and the default operand width.
package mult_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/mult_ctrl.sv
// Sequencer for mult_seq_n: owns the FSM, the bit counter and the busy/done flags.
// The datapath is steered through accept/step/fin.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for start; z holds the last result
//   CALC  | one shift-add step per cycle, counter runs WIDTH down to 0
//   DONE  | result ready in the accumulator; z and done update on exit
module mult_ctrl
   import mult_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   output logic busy,
   output logic done,
   output logic accept,
   output logic step,
   output logic fin
);

   localparam int CW = $clog2(WIDTH + 1);

   state_t        state;
   logic [CW-1:0] cnt;

   assign accept = (state == IDLE) && start;
   assign step   = (state == CALC);
   assign fin    = (state == DONE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state <= CALC;
                  cnt   <= CW'(WIDTH);
                  busy  <= 1'b1;
               end
            end
            CALC: begin
               cnt <= cnt - 1'b1;
               // the step that takes the counter to zero is the last one
               if (cnt == CW'(1)) state <= DONE;
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b1;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/mult_seq_n.sv
// Sequential shift-add multiplier, one multiplier bit per cycle.
// Define MULT_SIGNED_EN to add the signed_mode port (two's-complement operands).
module mult_seq_n
   import mult_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic               clk,
   input  logic               reset,
`ifdef MULT_SIGNED_EN
   input  logic               signed_mode,
`endif
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] z
);

   logic               accept;
   logic               step;
   logic               fin;
   logic [2*WIDTH-1:0] mcand;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   mplier;
   logic               neg;
   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic               neg_in;

   mult_ctrl #(.WIDTH(WIDTH)) u_ctrl (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .busy   (busy),
      .done   (done),
      .accept (accept),
      .step   (step),
      .fin    (fin)
   );

   // Magnitudes are unsigned WIDTH-bit values, so -2^(WIDTH-1) maps to 2^(WIDTH-1) exactly.
   always_comb begin
      mag_a  = a;
      mag_b  = b;
      neg_in = 1'b0;
`ifdef MULT_SIGNED_EN
      if (signed_mode) begin
         if (a[WIDTH-1]) mag_a = -a;
         if (b[WIDTH-1]) mag_b = -b;
         neg_in = a[WIDTH-1] ^ b[WIDTH-1];
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mcand  <= '0;
         acc    <= '0;
         mplier <= '0;
         neg    <= 1'b0;
         z      <= '0;
      end else if (accept) begin
         mcand  <= {{WIDTH{1'b0}}, mag_a};
         mplier <= mag_b;
         acc    <= '0;
         neg    <= neg_in;
      end else if (step) begin
         if (mplier[0]) acc <= acc + mcand;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
      end else if (fin) begin
         z <= neg ? -acc : acc;
      end
   end

endmodule

// File: tb/tb_mult_seq_n.sv
// Self-checking bench for mult_seq_n: WIDTH=4 and WIDTH=8 instances against an
// arithmetic reference model, directed and random operands.
module tb_mult_seq_n;

`ifdef MULT_SIGNED_EN
   localparam bit SIGNED_ON = 1'b1;
`else
   localparam bit SIGNED_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start4 = 1'b0;
   logic [3:0]  a4 = '0;
   logic [3:0]  b4 = '0;
   logic        sm4 = 1'b0;
   logic        busy4;
   logic        done4;
   logic [7:0]  z4;
   logic        start8 = 1'b0;
   logic [7:0]  a8 = '0;
   logic [7:0]  b8 = '0;
   logic        sm8 = 1'b0;
   logic        busy8;
   logic        done8;
   logic [15:0] z8;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mult_seq_n #(.WIDTH(4)) dut4 (
      .clk         (clk),
      .reset       (reset),
`ifdef MULT_SIGNED_EN
      .signed_mode (sm4),
`endif
      .start       (start4),
      .a           (a4),
      .b           (b4),
      .busy        (busy4),
      .done        (done4),
      .z           (z4)
   );

   mult_seq_n #(.WIDTH(8)) dut8 (
      .clk         (clk),
      .reset       (reset),
`ifdef MULT_SIGNED_EN
      .signed_mode (sm8),
`endif
      .start       (start8),
      .a           (a8),
      .b           (b8),
      .busy        (busy8),
      .done        (done8),
      .z           (z8)
   );

   function automatic logic [7:0] model4(input logic [3:0] ta, input logic [3:0] tb, input logic sm);
      int va;
      int vb;
      va = int'(ta);
      vb = int'(tb);
      if (SIGNED_ON && sm) begin
         if (ta[3]) va = va - 16;
         if (tb[3]) vb = vb - 16;
      end
      return 8'(va * vb);
   endfunction

   function automatic logic [15:0] model8(input logic [7:0] ta, input logic [7:0] tb, input logic sm);
      int va;
      int vb;
      va = int'(ta);
      vb = int'(tb);
      if (SIGNED_ON && sm) begin
         if (ta[7]) va = va - 256;
         if (tb[7]) vb = vb - 256;
      end
      return 16'(va * vb);
   endfunction

   task automatic op4(input logic [3:0] ta, input logic [3:0] tb, input logic sm, input string nm);
      logic [7:0] exp;
      logic [7:0] zprev;
      int         ndone;
      int         lat;
      bit         zheld;
      exp   = model4(ta, tb, sm);
      zprev = z4;
      ndone = 0;
      lat   = 0;
      zheld = 1'b1;
      a4 = ta; b4 = tb; sm4 = sm; start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0;
      a4 = 4'($urandom); b4 = 4'($urandom);
      checks++;
      if (busy4 !== 1'b1) begin
         errors++; $display("FAIL %s busy: got %b expected 1", nm, busy4);
      end
      for (int k = 2; k <= 10; k++) begin
         @(posedge clk); #1;
         if (done4 === 1'b1) begin
            ndone++;
            if (lat == 0) lat = k;
            checks++;
            if (z4 !== exp) begin
               errors++; $display("FAIL %s z: got %0d expected %0d", nm, z4, exp);
            end
         end else if (lat == 0 && z4 !== zprev) begin
            zheld = 1'b0;
         end
      end
      checks++;
      if (ndone != 1 || lat != 6) begin
         errors++; $display("FAIL %s done: got %0d pulses at edge %0d expected 1 at edge 6", nm, ndone, lat);
      end
      checks++;
      if (!zheld) begin
         errors++; $display("FAIL %s zhold: z changed before done, expected %0d held", nm, zprev);
      end
      checks++;
      if (busy4 !== 1'b0) begin
         errors++; $display("FAIL %s idle busy: got %b expected 0", nm, busy4);
      end
   endtask

   task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input string nm);
      logic [15:0] exp;
      int          ndone;
      int          lat;
      exp   = model8(ta, tb, 1'b0);
      ndone = 0;
      lat   = 0;
      a8 = ta; b8 = tb; sm8 = 1'b0; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      a8 = 8'($urandom); b8 = 8'($urandom);
      for (int k = 2; k <= 14; k++) begin
         @(posedge clk); #1;
         if (done8 === 1'b1) begin
            ndone++;
            if (lat == 0) lat = k;
            checks++;
            if (z8 !== exp) begin
               errors++; $display("FAIL %s z: got %0d expected %0d", nm, z8, exp);
            end
         end
      end
      checks++;
      if (ndone != 1 || lat != 10) begin
         errors++; $display("FAIL %s done: got %0d pulses at edge %0d expected 1 at edge 10", nm, ndone, lat);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start4 = 1'b1; start8 = 1'b1; a4 = 4'd5; b4 = 4'd5;
      repeat (2) @(posedge clk);
      #1;
      start4 = 1'b0; start8 = 1'b0; reset = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (busy4 !== 1'b0 || done4 !== 1'b0 || z4 !== 8'h00) begin
         errors++; $display("FAIL reset4: got busy=%b done=%b z=%0h expected 0/0/00", busy4, done4, z4);
      end
      checks++;
      if (busy8 !== 1'b0 || done8 !== 1'b0 || z8 !== 16'h0000) begin
         errors++; $display("FAIL reset8: got busy=%b done=%b z=%0h expected 0/0/0000", busy8, done8, z8);
      end
   endtask

   task automatic test_products();
      op4(4'b0011, 4'b0001, 1'b0, "p_3x1");
      op4(4'b0100, 4'b0100, 1'b0, "p_4x4");
      op4(4'b0000, 4'b0000, 1'b0, "p_0x0");
      op4(4'b0010, 4'b1000, 1'b0, "p_2x8");
      op4(4'b1111, 4'b0001, 1'b0, "p_15x1");
   endtask

   task automatic test_idle_hold();
      logic [7:0] zprev;
      bit         ok;
      zprev = z4;
      ok    = 1'b1;
      for (int k = 0; k < 5; k++) begin
         a4 = 4'($urandom); b4 = 4'($urandom);
         @(posedge clk); #1;
         if (z4 !== zprev || done4 !== 1'b0 || busy4 !== 1'b0) ok = 1'b0;
      end
      checks++;
      if (!ok) begin
         errors++; $display("FAIL idle_hold: z=%0d done=%b busy=%b expected z=%0d, 0, 0", z4, done4, busy4, zprev);
      end
   endtask

   task automatic test_back_to_back();
      int ndone;
      ndone = 0;
      a4 = 4'd15; b4 = 4'd15; sm4 = 1'b0; start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0;
      @(posedge clk); #1;
      start4 = 1'b1; a4 = 4'd1; b4 = 4'd1;
      for (int k = 3; k <= 12; k++) begin
         @(posedge clk); #1;
         start4 = 1'b0;
         if (done4 === 1'b1) begin
            ndone++;
            checks++;
            if (z4 !== 8'd225) begin
               errors++; $display("FAIL b2b z: got %0d expected 225", z4);
            end
         end
      end
      checks++;
      if (ndone != 1) begin
         errors++; $display("FAIL b2b done count: got %0d expected 1", ndone);
      end
   endtask

   task automatic test_abort();
      int ndone;
      ndone = 0;
      a4 = 4'd7; b4 = 4'd9; sm4 = 1'b0; start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0;
      for (int k = 2; k <= 3; k++) begin
         @(posedge clk); #1;
         if (done4 === 1'b1) ndone++;
      end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      if (done4 === 1'b1) ndone++;
      checks++;
      if (ndone != 0 || busy4 !== 1'b0 || z4 !== 8'd0) begin
         errors++; $display("FAIL abort: got done pulses=%0d busy=%b z=%0d expected 0/0/0", ndone, busy4, z4);
      end
      op4(4'd2, 4'd3, 1'b0, "abort_restart");
   endtask

   task automatic test_signed();
      if (SIGNED_ON) begin
         op4(4'b1101, 4'b0010, 1'b1, "s_m3x2");
         op4(4'b1000, 4'b1000, 1'b1, "s_m8xm8");
         op4(4'b1000, 4'b0111, 1'b1, "s_m8x7");
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 16; i++) begin
         op4(4'($urandom), 4'($urandom), SIGNED_ON ? 1'($urandom) : 1'b0, "rand4");
      end
   endtask

   task automatic test_wide();
      op8(8'd255, 8'd255, "w_255x255");
      for (int i = 0; i < 6; i++) begin
         op8(8'($urandom), 8'($urandom), "rand8");
      end
   endtask

   initial begin
      test_reset();
      test_products();
      test_idle_hold();
      test_back_to_back();
      test_abort();
      test_signed();
      test_random();
      test_wide();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mult_seq_n.md
MULT_SEQ_N -- requirements
Module: mult_seq_n

Interface
- REQ-001 Parameter WIDTH, default 8: operand width in bits, legal range 2..32.
- REQ-002 clk  input  1  sole clock, all state updates on rising edge.
- REQ-003 reset  input  1  synchronous, active-high reset.
- REQ-004 start  input  1  request pulse; sampled only in IDLE.
- REQ-005 a  input  WIDTH  multiplicand, captured on accepted start.
- REQ-006 b  input  WIDTH  multiplier, captured on accepted start.
- REQ-007 signed_mode  input  1  1 = two's-complement operands; present only when MULT_SIGNED_EN is defined.
- REQ-008 busy  output  1  high while an operation is in progress (CALC or DONE).
- REQ-009 done  output  1  one-cycle pulse marking z valid for the just-finished operation.
- REQ-010 z  output  2*WIDTH  product; holds last result until the next operation completes.

Function
- REQ-011 FSM states SHALL be IDLE, CALC, DONE.
- REQ-012 IDLE with start=1 SHALL latch a, b (and signed_mode), clear the accumulator, load bit counter to WIDTH, and go to CALC next cycle.
- REQ-013 IDLE with start=0 SHALL remain in IDLE with outputs unchanged.
- REQ-014 CALC SHALL perform one shift-add step per cycle: add the shifted multiplicand to the accumulator if the current multiplier LSB is 1, shift the multiplier right, decrement the counter.
- REQ-015 CALC SHALL last exactly WIDTH cycles, then enter DONE.
- REQ-016 On DONE, z SHALL be loaded with the full 2*WIDTH product, done SHALL be 1 for that single cycle, and the next state SHALL be IDLE.
- REQ-017 Latency: with start sampled at edge N, done=1 and z valid SHALL be seen during the cycle after edge N+WIDTH+1; throughput is one result per WIDTH+2 cycles.
- REQ-018 start asserted while busy=1 SHALL be ignored, with no queuing.
- REQ-019 Changes on a/b after acceptance SHALL NOT affect the running operation.
- REQ-020 Unsigned product SHALL be exact, with no truncation (max (2^WIDTH-1)^2 fits in 2*WIDTH bits).
- REQ-021 z SHALL change only on the DONE transition.

Reset
- REQ-022 reset=1 at a rising edge SHALL force state IDLE, busy=0, done=0, z=0, and clear the accumulator and counter, regardless of state.
- REQ-023 A reset during CALC or DONE SHALL abort the operation with no done pulse; a start in the first cycle after reset deasserts SHALL be accepted.
- REQ-024 reset SHALL take priority over start in the same cycle.

Configuration
- REQ-025 Macro MULT_SIGNED_EN defined: the signed_mode port SHALL exist.
  - With signed_mode=1, operands are converted to magnitudes at acceptance, and the product is negated at DONE if the operand signs differ.
  - Latency SHALL be unchanged.
  - The most-negative operand (-2^(WIDTH-1)) SHALL be handled exactly.
- REQ-026 Macro MULT_SIGNED_EN undefined: no signed_mode port, and all operands are treated as unsigned.

Structure
- REQ-027 A shared package mult_pkg SHALL hold the FSM state typedef (IDLE/CALC/DONE) and the default-width constant.
- REQ-028 Counter width SHALL be $clog2(WIDTH+1).
- REQ-029 Sub-module mult_ctrl SHALL contain the FSM, bit counter, busy and done; the datapath (accumulator, shift registers, sign fix) stays in mult_seq_n.

Verification (WIDTH=4 unless stated)
- REQ-030 Reset held 2 cycles, then released -> busy=0, done=0, z=8'h00.
- REQ-031 Products, each start pulsed in IDLE:
  - a=4'b0011, b=4'b0001 -> z=8'd3, with done exactly 6 edges after start.
  - a=4'b0100, b=4'b0100 -> z=8'd16.
  - a=4'b0000, b=4'b0000 -> z=8'd0.
  - a=4'b0010, b=4'b1000 -> z=8'd16.
  - a=4'b1111, b=4'b0001 -> z=8'd15.
- REQ-032 a=15, b=15, then start pulsed again and operands changed to 1/1 two cycles later -> single done, z=8'd225, second start ignored.
- REQ-033 Start with a=7, b=9; reset in cycle 3 of CALC -> no done pulse, z=0; a new start with 2×3 -> z=8'd6.
- REQ-034 MULT_SIGNED_EN, signed_mode=1:
  - a=4'b1101 (-3), b=4'b0010 -> z=8'hFA.
  - a=4'b1000, b=4'b1000 -> z=8'd64.
- REQ-035 WIDTH=8: a=255, b=255 -> z=16'd65025, done 10 edges after start.
